// File: rtl/automata_pkg.sv
// Shared types and helpers for the automaton row pipeline (word width, fill counter
// width, popcount helpers).
package automata_pkg;

  localparam int WORD_W = 20;
  localparam int CNT_W  = 5;

  typedef logic [WORD_W-1:0] row_word_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  // Width needed to count every cell of a row of the given number of words.
  function automatic int pop_width(input int words);
    return $clog2(words * WORD_W + 1);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input row_word_t w);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < WORD_W; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/row_packer_bit_accumulator.sv
// Bit/word accumulator for row_packer: fills a 20-bit word from single-bit or
// full-word beats, zero-pads on the row's last beat and flags dropped partial words.
module bit_accumulator
  import automata_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clear,
  input  logic      accept,
  input  logic      single,
  input  row_word_t bits,
  input  logic      last,
  input  logic      take,
  output logic      full,
  output row_word_t word,
  output logic      last_tag,
  output logic      err
);

  row_word_t        acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tag_q, tag_d;
  logic             err_q, err_d;

  // Next-state: a transfer empties the accumulator first, so a beat in the same
  // cycle lands in a clean word.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    err_d = err_q;
    if (take) begin
      acc_d = {WORD_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
      tag_d = 1'b0;
    end else begin
      tag_d = tag_q;
    end
    if (accept) begin
      if (single) begin
        acc_d = {acc_d[WORD_W-2:0], bits[WORD_W-1]};
        cnt_d = cnt_d + CNT_W'(1);
      end else begin
        err_d = err_q | (cnt_d != {CNT_W{1'b0}});
        acc_d = bits;
        cnt_d = CNT_FULL;
      end
      if (last) begin
        acc_d = acc_d << (CNT_FULL - cnt_d);
        cnt_d = CNT_FULL;
        tag_d = 1'b1;
      end else begin
        tag_d = tag_d;
      end
    end else begin
      err_d = err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= {WORD_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      tag_q <= 1'b0;
      err_q <= 1'b0;
    end else if (clear) begin
      acc_q <= {WORD_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      tag_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end

  assign full     = (cnt_q == CNT_FULL);
  assign word     = acc_q;
  assign last_tag = tag_q;
  assign err      = err_q;

endmodule

// File: rtl/row_packer.sv
// Packs cell-state beats into 20-bit row words with write address and row_done.
// Optional feature macro: ROW_POPCOUNT_EN adds the row_pop per-row ones count.
module row_packer
  import automata_pkg::*;
#(
  parameter  int ROW_WORDS = 32,
  localparam int ADDR_W    = $clog2(ROW_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_single,
  input  logic [WORD_W-1:0] in_bits,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              row_done,
`ifdef ROW_POPCOUNT_EN
  output logic [pop_width(ROW_WORDS)-1:0] row_pop,
`endif
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WORDS - 1);

  logic      acc_full, acc_tag, out_free, take, accept, hs;
  row_word_t acc_word;

  logic              out_valid_q, out_valid_d;
  row_word_t         out_word_q, out_word_d;
  logic              out_tag_q, out_tag_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              row_done_q, row_done_d;

  assign out_free = !out_valid_q || out_ready;
  assign take     = acc_full && out_free && !clear;
  assign in_ready = !clear && (!acc_full || out_free);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid_q && out_ready;

  bit_accumulator u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .accept   (accept),
    .single   (in_single),
    .bits     (in_bits),
    .last     (in_last),
    .take     (take),
    .full     (acc_full),
    .word     (acc_word),
    .last_tag (acc_tag),
    .err      (err)
  );

  // Output register and address: a transfer can refill the register in the same
  // cycle it is handed off.
  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_tag_d   = out_tag_q;
    out_addr_d  = out_addr_q;
    row_done_d  = hs && out_last;
    if (take) begin
      out_valid_d = 1'b1;
      out_word_d  = acc_word;
      out_tag_d   = acc_tag;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (hs) begin
      out_addr_d = out_last ? {ADDR_W{1'b0}} : out_addr_q + ADDR_W'(1);
    end else begin
      out_addr_d = out_addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= {WORD_W{1'b0}};
      out_tag_q   <= 1'b0;
      out_addr_q  <= {ADDR_W{1'b0}};
      row_done_q  <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_word_q  <= {WORD_W{1'b0}};
      out_tag_q   <= 1'b0;
      out_addr_q  <= {ADDR_W{1'b0}};
      row_done_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_tag_q   <= out_tag_d;
      out_addr_q  <= out_addr_d;
      row_done_q  <= row_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_valid_q && (out_tag_q || out_addr_q == LAST_ADDR);
  assign row_done  = row_done_q;

`ifdef ROW_POPCOUNT_EN
  localparam int POP_W = pop_width(ROW_WORDS);

  logic [POP_W-1:0] row_pop_q, row_pop_d;

  // The total stays visible during the row_done cycle, then restarts.
  always_comb begin
    row_pop_d = (row_done_q ? {POP_W{1'b0}} : row_pop_q)
              + (hs ? POP_W'(popcount(out_word_q)) : {POP_W{1'b0}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_pop_q <= {POP_W{1'b0}};
    end else if (clear) begin
      row_pop_q <= {POP_W{1'b0}};
    end else begin
      row_pop_q <= row_pop_d;
    end
  end

  assign row_pop = row_pop_q;
`endif

endmodule

// File: tb/tb_row_packer.sv
// Scoreboard bench for row_packer: expected words are queued as beats are driven
// and compared at each output handshake.
module tb_row_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_single = 1'b0;
  logic [19:0] in_bits = 20'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_word;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        row_done;
  logic        err;
`ifdef ROW_POPCOUNT_EN
  logic [9:0]  row_pop;
`endif

  typedef struct packed {
    logic [19:0] w;
    logic [4:0]  a;
    logic        l;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;
  logic exp_done = 1'b0;

  row_packer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_single (in_single),
    .in_bits   (in_bits),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .row_done  (row_done),
`ifdef ROW_POPCOUNT_EN
    .row_pop   (row_pop),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare every handshake against the scoreboard, and row_done against
  // the previous cycle's last-word handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_done = 1'b0;
    end else begin
      check("row_done", 32'(row_done), 32'(exp_done));
      exp_done = out_valid && out_ready && out_last && !clear;
      if (out_valid && out_ready && !clear) begin
        if (q.size() == 0) begin
          check("spurious_word", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("out_word", 32'(out_word), 32'(e.w));
          check("out_addr", 32'(out_addr), 32'(e.a));
          check("out_last", 32'(out_last), 32'(e.l));
        end
      end
    end
  end

  task automatic push(input logic [19:0] w, input logic [4:0] a, input logic l);
    exp_t x;
    x.w = w; x.a = a; x.l = l;
    q.push_back(x);
  endtask

  task automatic beat(input logic s, input logic [19:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_single = s; in_bits = b; in_last = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("beat_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && q.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    check("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_word"},  32'(out_word),  32'd0);
    check({tag, "_addr"},  32'(out_addr),  32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_done"},  32'(row_done),  32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
`ifdef ROW_POPCOUNT_EN
    check({tag, "_pop"},   32'(row_pop),   32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full row of back-to-back words.
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push(20'h0ABCD + 20'(i * 97), 5'(i), (i == 31));
    t0 = cyc;
    for (int i = 0; i < 32; i++) beat(1'b0, 20'h0ABCD + 20'(i * 97), 1'b0);
    drain();
    check("thruput", 32'((cyc - t0) <= 34), 32'd1);
    check("row1_done", 32'(row_done), 32'd1);
    check("row1_addr0", 32'(out_addr), 32'd0);
    check("row1_err", 32'(err), 32'd0);

    // Alternating single bits.
    do_clear();
    push(20'hAAAAA, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) beat(1'b1, (i % 2 == 0) ? 20'h80000 : 20'h00000, 1'b0);
    drain();

    // Short padded final word.
    push(20'hF8000, 5'd1, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 20'hFFFFF, (i == 4));
    drain();
    check("pad_done", 32'(row_done), 32'd1);
    check("pad_addr0", 32'(out_addr), 32'd0);

    // Backpressure.
    do_clear();
    out_ready = 1'b0;
    push(20'h11111, 5'd0, 1'b0);
    push(20'h22222, 5'd1, 1'b0);
    beat(1'b0, 20'h11111, 1'b0);
    beat(1'b0, 20'h22222, 1'b0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_word", 32'(out_word), 32'h11111);
    check("bp_addr", 32'(out_addr), 32'd0);
    check("bp_ready2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain();
    check("bp_addr2", 32'(out_addr), 32'd2);

    // Partial word dropped by a word beat.
    do_clear();
    push(20'h12345, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) beat(1'b1, 20'h80000, 1'b0);
    beat(1'b0, 20'h12345, 1'b0);
    drain();
    check("err_set", 32'(err), 32'd1);
    do_clear();
    check("err_clr", 32'(err), 32'd0);
    check("clr_addr", 32'(out_addr), 32'd0);

`ifdef ROW_POPCOUNT_EN
    for (int i = 0; i < 32; i++) push(20'hFFFFF, 5'(i), (i == 31));
    for (int i = 0; i < 32; i++) beat(1'b0, 20'hFFFFF, 1'b0);
    drain();
    check("pop_done", 32'(row_done), 32'd1);
    check("row_pop", 32'(row_pop), 32'd640);
    @(posedge clk); #1;
    check("pop_restart", 32'(row_pop), 32'd0);
`endif

    // Reset mid-row aborts everything held.
    out_ready = 1'b0;
    beat(1'b0, 20'h33333, 1'b0);
    beat(1'b1, 20'h80000, 1'b0);
    check("mid_valid", 32'(out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(20'h55555, 5'd0, 1'b0);
    beat(1'b0, 20'h55555, 1'b0);
    drain();
    check("post_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_packer.md
# row_packer

Collects freshly computed cell-state bits from the automaton update logic and packs them into 20-bit row words for write-back to row memory. It accepts either a full 20-bit word or a single bit per beat and presents completed words with a write address over a valid/ready handshake. It sits on the write side of the row pipeline, opposite the shift buffer that feeds cell windows into the update logic.

## Interface
- ROW_WORDS, 32, words per automaton row; derived localparam ADDR_W = $clog2(ROW_WORDS).
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: drops all held data and counters.
- in_valid  in  1  input beat offered.
- in_ready  out  1  input beat accepted this cycle when in_valid is also high.
- in_single  in  1  1: beat carries one bit, in_bits[19]; 0: beat carries all 20 bits.
- in_bits  in  20  cell data, MSB = leftmost cell.
- in_last  in  1  beat closes the row; the partial word is zero-padded.
- out_valid  out  1  out_word/out_addr/out_last valid.
- out_ready  in  1  downstream takes the word.
- out_word  out  20  packed word, MSB = leftmost cell.
- out_addr  out  ADDR_W  word index within the row.
- out_last  out  1  final word of the row.
- row_done  out  1  one-cycle pulse after the last word's handshake.
- err  out  1  sticky: a word beat arrived while the accumulator held a partial word.

## Operation
- Accumulator acc[19:0] with fill count cnt (0..20). Output register holds one completed word.
- Single beat: acc <= {acc[18:0], in_bits[19]}, cnt+1.
- Word beat with cnt==0: acc <= in_bits, cnt <= 20.
- Word beat with cnt in 1..19: partial bits discarded, acc <= in_bits, cnt <= 20, err set.
- in_last on an accepted beat: after the beat's data is applied, acc is shifted left by (20 - cnt_new) with zero fill, cnt <= 20, and the word is tagged last.
- Transfer: when cnt==20 and the output is free (!out_valid || out_ready), acc moves to out_word with its last tag, and cnt <= 0.
- in_ready = !clear && (cnt != 20 || output free). A beat accepted in a transfer cycle starts the empty accumulator.
- out_addr increments on each output handshake. After the handshake of a word with out_last=1, it returns to 0.
- out_last = out_valid && (tagged last || out_addr == ROW_WORDS-1).
- clear: acc, cnt, output register, out_addr and err all go to 0; the input beat in that cycle is ignored.
- Priority: reset_n > clear > transfer/accept.

## Timing
- Reset values: out_valid 0, out_word 0, out_addr 0, out_last 0, row_done 0, err 0, in_ready 1.
- Latency: the beat that completes a word is at edge N. At edge N+1, out_valid rises (if the output is free).
- Throughput: one word per cycle in word mode with out_ready held at 1.
- Backpressure: when out_valid=1 and out_ready=0, out_word/out_addr/out_last hold stable. The accumulator may still fill to 20, after which in_ready=0.
- row_done is high in the cycle after the out_last handshake.
- Asserting reset_n low mid-row aborts the row; no partial word is emitted.

## Configuration
- ROW_POPCOUNT_EN defined:
  - Adds output row_pop, width $clog2(ROW_WORDS*20+1), reset 0.
  - Accumulates the number of 1s in each word at its output handshake.
  - Holds the row total in the row_done cycle; the accumulator restarts from 0 for the next row.
  - clear zeroes it.
- Not defined: port and logic absent; behaviour otherwise identical.

## Structure
- Shared package automata_pkg:
  - WORD_W = 20.
  - typedef logic [WORD_W-1:0] row_word_t.
  - Popcount width function.
- Sub-module bit_accumulator: acc, cnt, padding and err logic, exposing full, word and last-tag.
- Top level holds the output register, address counter, handshake, row_done and optional popcount.

## Test plan
- 32 back-to-back word beats, out_ready=1 -> one word/cycle, out_addr 0..31, out_last on 31, row_done the following cycle, err=0.
- 20 single beats with bits 1,0,1,0… -> out_word 20'hAAAAA, out_addr 0.
- 5 single beats of 1, in_last on the 5th -> out_word 20'hF8000, out_last=1, then out_addr back to 0 and row_done pulse.
- Two word beats 20'h11111, 20'h22222 with out_ready=0 -> in_ready drops after the second, out_word stable at 20'h11111. Raising out_ready emits both in order at addresses 0, 1.
- 3 single beats then word beat 20'h12345 -> err=1, out_word 20'h12345. A subsequent clear returns err to 0.
- Under ROW_POPCOUNT_EN, 32 words of 20'hFFFFF -> row_pop=640 in the row_done cycle. reset_n pulsed low mid-row -> all outputs at reset values.
